// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, sigma helpers, schedule FSM encoding.
package sha256_pkg;

  localparam int unsigned SHA256_ROUNDS      = 64;
  localparam int unsigned SHA256_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_EXPAND
  } sched_state_t;

  localparam logic [31:0] SHA256_K [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] shr32(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ shr32(x, 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ shr32(x, 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational 64x32 SHA-256 round-constant lookup.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  t,
  output logic [31:0] k
);

  assign k = SHA256_K[t];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule unit: streams M[0..15] in, expands W[16..63], one word per cycle.
// Optional macro SHA256_K_ROM_EN adds a registered K[t] output on out1.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  input  logic [DELAY_W-1:0] configdata
);

  sched_state_t       state;
  logic [DELAY_W-1:0] delay;
  logic [5:0]         t;
  logic [31:0]        win [SHA256_BLOCK_WORDS];
  logic [31:0]        w_exp;
  logic [31:0]        w_in;
  logic               active;

  // win[15] is W[t-1], win[0] is W[t-16].
  always_comb begin
    w_exp = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  end

  always_comb begin
    w_in   = (state == ST_LOAD) ? in0 : w_exp;
    active = (state == ST_LOAD) || (state == ST_EXPAND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b1;
      delay <= '0;
      t     <= '0;
      out0  <= '0;
      for (int unsigned i = 0; i < SHA256_BLOCK_WORDS; i++) begin
        win[i] <= '0;
      end
    end else if (run) begin
      delay <= configdata;
      t     <= '0;
      done  <= 1'b0;
      state <= (configdata != '0) ? ST_WAIT : ST_LOAD;
      for (int unsigned i = 0; i < SHA256_BLOCK_WORDS; i++) begin
        win[i] <= '0;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          delay <= delay - DELAY_W'(1);
          if (delay == DELAY_W'(1)) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD, ST_EXPAND: begin
          for (int unsigned i = 0; i < SHA256_BLOCK_WORDS - 1; i++) begin
            win[i] <= win[i+1];
          end
          win[SHA256_BLOCK_WORDS-1] <= w_in;
          out0 <= w_in;
          t    <= t + 6'd1;
          if (state == ST_LOAD && t == 6'(SHA256_BLOCK_WORDS - 1)) begin
            state <= ST_EXPAND;
          end
          if (state == ST_EXPAND && t == 6'(SHA256_ROUNDS - 1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SHA256_K_ROM_EN
  logic [31:0] k_t;

  sha256_k_rom u_k_rom (
    .t (t),
    .k (k_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1 <= '0;
    end else if (!run && active) begin
      out1 <= k_t;
    end
  end
`else
  logic unused_active;

  assign unused_active = active;
  assign out1          = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: expected W words queued per block, popped as out0 streams.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic [7:0]  configdata;

  sha256_msg_sched #(.DATA_W(32), .DELAY_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .done       (done),
    .in0        (in0),
    .out0       (out0),
    .out1       (out1),
    .configdata (configdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] msg    [16];
  logic [31:0] exp_w  [64];
  logic [31:0] sbq    [$];
  logic [31:0] last_w;
  logic [31:0] last_k;
  logic        is_abc;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_expected();
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
    sbq.delete();
    for (int i = 0; i < 64; i++) sbq.push_back(exp_w[i]);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    is_abc  = 1'b1;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    is_abc = 1'b0;
  endtask

  // Pulse run in cycle 0, then run cycles 1..ncyc checking done/out0/out1.
  task automatic play(input int d, input int ncyc);
    logic [31:0] ew;
    logic        exp_done;
    int          idx;
    build_expected();
    @(posedge clk); #1;
    configdata = 8'(d);
    run        = 1'b1;
    in0        = $urandom;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      run = 1'b0;
      if (c >= d + 1 && c <= d + 16) in0 = msg[c-d-1];
      else in0 = $urandom;
      @(negedge clk);
      exp_done = (c >= d + 65);
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL done c=%0d d=%0d got=%b want=%b", c, d, done, exp_done);
      end
      if (c >= d + 2 && c <= d + 65) begin
        idx = c - d - 2;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_empty idx=%0d got=%h want=queued", idx, out0);
        end else begin
          ew     = sbq.pop_front();
          last_w = ew;
          if (out0 !== ew) begin
            bad++;
            $display("FAIL w idx=%0d d=%0d got=%h want=%h", idx, d, out0, ew);
          end
        end
        if (is_abc && (idx == 16 || idx == 17 || idx == 63)) begin
          ew = (idx == 16) ? 32'h61626380 : (idx == 17) ? 32'h000F0000 : 32'h12B1EDEB;
          total++;
          if (out0 !== ew) begin
            bad++;
            $display("FAIL abc_w%0d got=%h want=%h", idx, out0, ew);
          end
        end
`ifdef SHA256_K_ROM_EN
        if (idx == 0 || idx == 63) begin
          last_k = (idx == 0) ? 32'h428A2F98 : 32'hC67178F2;
          total++;
          if (out1 !== last_k) begin
            bad++;
            $display("FAIL k idx=%0d got=%h want=%h", idx, out1, last_k);
          end
        end
`endif
      end else if (c > d + 65) begin
        total++;
        if (out0 !== last_w) begin
          bad++;
          $display("FAIL hold_w c=%0d got=%h want=%h", c, out0, last_w);
        end
`ifdef SHA256_K_ROM_EN
        total++;
        if (out1 !== last_k) begin
          bad++;
          $display("FAIL hold_k c=%0d got=%h want=%h", c, out1, last_k);
        end
`endif
      end
`ifndef SHA256_K_ROM_EN
      total++;
      if (out1 !== 32'h0) begin
        bad++;
        $display("FAIL k_tied c=%0d got=%h want=0", c, out1);
      end
`endif
    end
  endtask

  task automatic check_idle_reset(input string tag);
    total++;
    if (out0 !== 32'h0 || out1 !== 32'h0 || done !== 1'b1) begin
      bad++;
      $display("FAIL %s out0=%h out1=%h done=%b want 0/0/1", tag, out0, out1, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; in0 = '0; configdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in0 = $urandom;
      @(negedge clk);
      check_idle_reset("idle_in0_ignored");
    end
  endtask

  task automatic test_abc_d0();
    set_abc();
    play(0, 70);
  endtask

  task automatic test_abc_delay();
    set_abc();
    play(5, 75);
  endtask

  task automatic test_restart();
    set_random();
    play(3, 3 + 1 + 30);
    set_random();
    play(3, 75);
  endtask

  task automatic test_rst_mid();
    set_abc();
    play(0, 41);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("rst_mid_asserted");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset("rst_mid_released");
    play(0, 70);
  endtask

  task automatic test_back_to_back();
    set_random();
    play(0, 66);
    set_abc();
    play(2, 70);
  endtask

  initial begin
    last_w = '0;
    last_k = '0;
    is_abc = 1'b0;
    test_reset();
    test_abc_d0();
    test_abc_delay();
    test_restart();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Versat functional unit that produces the SHA-256 message schedule, W[0..63], for one 512-bit block. It streams 16 input words in and then runs the σ0/σ1 expansion for W[16..63], one word per cycle. Its W output feeds the `w` input of the SHA-256 compression-round unit, and its optional K output feeds that unit's `k` input. It follows the same `run`/`done`/delay-config control convention as the other Versat units, so both units can start from one `run` pulse with matched delays.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- DELAY_W, 8, width of the delay field in `configdata`.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  single-cycle start pulse; restarts the unit from any state.
- done  out  1  high while idle.
- in0  in  DATA_W  message word M[t], sampled during LOAD.
- out0  out  DATA_W  registered schedule word W[t].
- out1  out  DATA_W  registered round constant K[t], aligned with out0.
- configdata  in  DELAY_W  start delay D, in cycles.

## Operation
- States:
  - IDLE (reset state): `done`=1.
  - WAIT: count down the delay.
  - LOAD: take in the 16 message words.
  - EXPAND: compute W[16..63].
- `run` in any state: delay←D, t←0, W window cleared. Next state is WAIT if D≠0, else LOAD.
- WAIT: delay decrements each cycle. When delay==1, next state is LOAD.
- LOAD: each cycle, in0 is shifted into the 16-entry window, out0←in0, and t increments. At t==15, next state is EXPAND.
- EXPAND: each cycle computes W = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - The window shifts, out0←W, and t increments. At t==63, next state is IDLE.
- `run` outside IDLE aborts the current block with no partial `done`.
- In IDLE, out0 and out1 hold their last values (W[63], K[63]); in0 is ignored.
- Reset values: out0=0, out1=0, `done`=1, t=0, delay=0, window=0.
- `rst` mid-operation returns to IDLE with reset values on the following edge; `rst` has priority over `run`.

## Timing
- `run` is sampled at the edge ending cycle 0.
- For t<16, in0 for M[t] is sampled in cycle D+1+t.
- W[t] is visible on out0 during cycle D+2+t, for t=0..63: one word per cycle, no bubbles.
- `done` falls in cycle 1 and rises in cycle D+65.
- Matching the compression unit: that unit's first round consumes `w` one cycle after its own state load. Configure both units with the same D.

## Configuration
- SHA256_K_ROM_EN defined: out1 carries K[t] from the 64-entry constant ROM, registered together with out0. It holds K[63] in IDLE and resets to 0.
- SHA256_K_ROM_EN undefined: no ROM is instantiated; out1 is tied to 0. K is then supplied externally, e.g. from a Versat memory.

## Structure
- Shared package `sha256_pkg`:
  - K constant array.
  - Functions `rotr32`, `shr32`, `ssig0`, `ssig1`.
  - Constants `SHA256_ROUNDS`=64 and `SHA256_BLOCK_WORDS`=16.
  - The state-encoding typedef.
- Sub-module `sha256_k_rom`: combinational 64×32 lookup indexed by a 6-bit t, instantiated only under SHA256_K_ROM_EN.
- Top level: FSM, delay counter, 6-bit t counter, 16×32 window shift register, expansion adder.

## Test plan
- Reset held, then released -> out0=0, out1=0, `done`=1; in0 toggling while idle leaves the outputs at 0.
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), D=0:
  - out0 = W0 in cycle 2.
  - W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB.
  - `done` rises in cycle 65.
- Same block with D=5 -> identical sequence shifted by 5 cycles; in0 values presented during WAIT are ignored.
- SHA256_K_ROM_EN defined -> out1=0x428A2F98 alongside W0 and 0xC67178F2 alongside W63. Undefined -> out1=0 throughout.
- `run` reasserted at t=30 with a new block -> the old stream is abandoned; the new W0 appears D+2 cycles later and the full 64-word sequence is correct.
- `rst` asserted at t=40 -> the next cycle shows IDLE with out0=0 and `done`=1; a following `run` produces correct "abc" output.
